// File: rtl/bytecode_sequencer.sv
// Fetch/decode/execute controller for the 8-bit bytecode datapath. Bytes come from a
// synchronous ROM (data one cycle after address); the ALU is driven from scratch slots 3/0/1.
module bytecode_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DMEM_DEPTH = 16,
  parameter logic [7:0]  START_BYTE = 8'h7E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [7:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  output logic [7:0]        result,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              running,
  output logic              halted
);

  localparam int unsigned       DmemAw  = $clog2(DMEM_DEPTH);
  localparam logic [ADDR_W-1:0] EndAddr = {ADDR_W{1'b1}};

  localparam logic [DmemAw-1:0] SlotA   = DmemAw'(0);
  localparam logic [DmemAw-1:0] SlotB   = DmemAw'(1);
  localparam logic [DmemAw-1:0] SlotRes = DmemAw'(2);
  localparam logic [DmemAw-1:0] SlotOp  = DmemAw'(3);

  localparam logic [7:0] OpAlu3   = 8'h02;
  localparam logic [7:0] OpAlu2   = 8'h01;
  localparam logic [7:0] OpStore  = 8'hC2;
  localparam logic [7:0] OpMove   = 8'hE2;
  localparam logic [7:0] OpPrint  = 8'h81;
  localparam logic [7:0] OpCall   = 8'hAA;
  localparam logic [7:0] OpCallIf = 8'hDA;
  localparam logic [7:0] OpRet    = 8'h55;
  localparam logic [7:0] OpHalt   = 8'hFF;

  typedef enum logic [3:0] {
    StScanIssue, StScanCap, StOpIssue, StOpCap, StArgIssue, StArgCap, StExec, StOutWait, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ret_addr_q, ret_addr_d;
  logic              ret_valid_q, ret_valid_d;
  logic [7:0]        opcode_q, opcode_d, arg0_q, arg0_d, arg1_q, arg1_d;
  logic [1:0]        arg_cnt_q, arg_cnt_d, arg_idx_q, arg_idx_d;
  logic [7:0]        result_q, result_d, out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, running_q, running_d, halted_q, halted_d;
  logic [7:0]        mem_q [DMEM_DEPTH];
  logic [7:0]        mem_d [DMEM_DEPTH];

  logic              at_end, is_alu, do_call, dec_known;
  logic [1:0]        dec_cnt;
  logic [DmemAw-1:0] x_idx, y_idx;

  assign at_end = (pc_q == EndAddr);
  assign is_alu = (opcode_q == OpAlu3) || (opcode_q == OpAlu2);
  assign x_idx  = arg0_q[DmemAw-1:0];
  assign y_idx  = arg1_q[DmemAw-1:0];

  always_comb begin
    dec_known = 1'b1;
    dec_cnt   = 2'd0;
    case (imem_data)
      OpAlu3:                   dec_cnt = 2'd3;
      OpAlu2, OpStore, OpMove:  dec_cnt = 2'd2;
      OpPrint, OpCall, OpCallIf: dec_cnt = 2'd1;
      OpRet, OpHalt:            dec_cnt = 2'd0;
      default:                  dec_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = ret_valid_q;
    opcode_d    = opcode_q;
    arg0_d      = arg0_q;
    arg1_d      = arg1_q;
    arg_cnt_d   = arg_cnt_q;
    arg_idx_d   = arg_idx_q;
    result_d    = result_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    running_d   = running_q;
    halted_d    = halted_q;
    mem_d       = mem_q;
    do_call     = 1'b0;
    if (enable) begin
      unique case (state_q)
        StScanIssue: state_d = at_end ? StHalt : StScanCap;
        StScanCap: begin
          pc_d = pc_q + ADDR_W'(1);
          if (imem_data == START_BYTE) begin
            running_d = 1'b1;
            state_d   = StOpIssue;
          end else begin
            state_d = StScanIssue;
          end
        end
        StOpIssue: state_d = at_end ? StHalt : StOpCap;
        StOpCap: begin
          pc_d      = pc_q + ADDR_W'(1);
          opcode_d  = imem_data;
          arg_cnt_d = dec_cnt;
          arg_idx_d = 2'd0;
          if (!dec_known)           state_d = StOpIssue;
          else if (dec_cnt == 2'd0) state_d = StExec;
          else                      state_d = StArgIssue;
        end
        StArgIssue: state_d = at_end ? StHalt : StArgCap;
        StArgCap: begin
          pc_d = pc_q + ADDR_W'(1);
          if (arg_idx_q == 2'd0) arg0_d = imem_data;
          if (arg_idx_q == 2'd1) arg1_d = imem_data;
          // ALU operands land in their slots as they arrive so the ALU sees them during EXEC
          if (is_alu) begin
            case (arg_idx_q)
              2'd0:    mem_d[SlotOp] = imem_data;
              2'd1:    mem_d[SlotA]  = imem_data;
              default: mem_d[SlotB]  = imem_data;
            endcase
          end
          arg_idx_d = arg_idx_q + 2'd1;
          state_d   = (arg_idx_d == arg_cnt_q) ? StExec : StArgIssue;
        end
        StExec: begin
          state_d = StOpIssue;
          case (opcode_q)
            OpAlu3, OpAlu2: begin
              mem_d[SlotRes] = alu_result;
              result_d       = alu_result;
            end
            OpStore: begin
              mem_d[x_idx] = arg1_q;
              result_d     = arg1_q;
            end
            OpMove: begin
              mem_d[x_idx] = mem_q[y_idx];
              result_d     = mem_q[y_idx];
            end
            OpPrint: begin
              out_data_d  = mem_q[x_idx];
              out_valid_d = 1'b1;
              state_d     = StOutWait;
            end
            OpCall:   do_call = 1'b1;
            OpCallIf: do_call = (mem_q[SlotRes] == 8'h01);
            OpRet: begin
              if (ret_valid_q) begin
                pc_d        = ret_addr_q;
                ret_valid_d = 1'b0;
              end
            end
            OpHalt:  state_d = StHalt;
            default: ;
          endcase
          // pc already points past the operand, which is the return address
          if (do_call) begin
            ret_addr_d  = pc_q;
            ret_valid_d = 1'b1;
            pc_d        = ADDR_W'(arg0_q);
          end
        end
        StOutWait: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StOpIssue;
          end
        end
        StHalt: ;
      endcase
      if (state_d == StHalt) begin
        halted_d  = 1'b1;
        running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StScanIssue;
      pc_q        <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      opcode_q    <= 8'h00;
      arg0_q      <= 8'h00;
      arg1_q      <= 8'h00;
      arg_cnt_q   <= 2'd0;
      arg_idx_q   <= 2'd0;
      result_q    <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      mem_q       <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      opcode_q    <= opcode_d;
      arg0_q      <= arg0_d;
      arg1_q      <= arg1_d;
      arg_cnt_q   <= arg_cnt_d;
      arg_idx_q   <= arg_idx_d;
      result_q    <= result_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      mem_q       <= mem_d;
    end
  end

  assign imem_addr = pc_q;
  assign alu_op    = mem_q[SlotOp];
  assign alu_a     = mem_q[SlotA];
  assign alu_b     = mem_q[SlotB];
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign running   = running_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Bench for bytecode_sequencer: directed program table, hand-written timing/corner sequences,
// and random programs checked against an instruction-level interpreter.
module tb_bytecode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] imem_addr, imem_data, alu_op, alu_a, alu_b, alu_result, result, out_data;
  logic       out_valid, running, halted;

  logic [7:0] rom [256];
  logic [7:0] got_q [$];
  int         got_base = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         gp;
  bit         saw_running;

  logic [7:0] m_mem [16];
  logic [7:0] m_prints [$];
  logic [7:0] m_result, m_pc;

  typedef struct {
    logic [127:0] prog;
    int           len;
    logic [7:0]   sub_at;
    logic [127:0] sub;
    int           sub_len;
    int           n_prints;
    logic [7:0]   first_print;
    logic [7:0]   exp_result;
    logic [7:0]   exp_pc;
  } vec_t;
  vec_t tbl [8];

  bytecode_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .result(result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .running(running),
    .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= rom[imem_addr];

  function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      8'h00:   return a + b;
      8'h01:   return a - b;
      8'h02:   return a & b;
      8'h03:   return a | b;
      8'h04:   return a ^ b;
      8'h05:   return (a == b) ? 8'h01 : 8'h00;
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

  always @(posedge clk) if (!rst && enable && out_valid && out_ready) got_q.push_back(out_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1; saw_running = 1'b0;
    step(2);
    got_base = got_q.size();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int bound);
    int k = 0;
    while (!halted && k < bound) begin
      step(1);
      if (running) saw_running = 1'b1;
      k++;
    end
    chk("halted", 32'(halted), 32'd1);
  endtask

  task automatic wait_out_valid(input int bound);
    int k = 0;
    while (!out_valid && k < bound) begin step(1); k++; end
    chk("out_valid_rise", 32'(out_valid), 32'd1);
  endtask

  function automatic int nprint();
    return got_q.size() - got_base;
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Bytes are listed most-significant first in the packed image
  task automatic rom_load(input logic [7:0] base, input logic [127:0] p, input int len);
    for (int i = 0; i < len; i++) rom[8'(base + i)] = p[(len-1-i)*8 +: 8];
  endtask

  task automatic put(input logic [7:0] b);
    rom[8'(gp)] = b;
    gp++;
  endtask

  task automatic gen_instr(input int kinds);
    int k = $urandom_range(0, kinds - 1);
    case (k)
      0: begin put(8'h02); put(8'($urandom_range(0, 6))); put(8'($urandom_range(0, 3)));
               put(8'($urandom_range(0, 3))); end
      1: begin put(8'h01); put(8'($urandom_range(0, 6))); put(8'($urandom)); end
      2: begin put(8'hC2); put(8'($urandom_range(0, 31))); put(8'($urandom)); end
      3: begin put(8'hE2); put(8'($urandom_range(0, 31))); put(8'($urandom_range(0, 31))); end
      4: begin put(8'h81); put(8'($urandom_range(0, 31))); end
      5: put(8'h3C);
      6: put(8'h55);
      7: begin put(8'hAA); put(8'hC0); end
      default: begin put(8'hDA); put(8'hC0); end
    endcase
  endtask

  task automatic gen_prog();
    rom_clear();
    gp = 0;
    repeat ($urandom_range(0, 3)) put(8'($urandom_range(0, 8'h7D)));
    put(8'h7E);
    repeat ($urandom_range(3, 8)) gen_instr(9);
    put(8'hFF);
    gp = 8'hC0;
    repeat ($urandom_range(1, 3)) gen_instr(6);
    put(8'h55);
  endtask

  // Instruction-level interpreter over the ROM image
  task automatic model_run();
    logic [7:0] pc, op, ret, v;
    logic [7:0] a [3];
    logic       rv;
    bit         found, cut;
    int         n;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_prints.delete();
    m_result = 8'h00; pc = 8'h00; ret = 8'h00; rv = 1'b0; found = 1'b0;
    while (pc != 8'hFF && !found) begin
      v = rom[pc]; pc++;
      if (v == 8'h7E) found = 1'b1;
    end
    for (int s = 0; s < 4000 && found; s++) begin
      if (pc == 8'hFF) break;
      op = rom[pc]; pc++;
      case (op)
        8'h02:                n = 3;
        8'h01, 8'hC2, 8'hE2:  n = 2;
        8'h81, 8'hAA, 8'hDA:  n = 1;
        8'h55, 8'hFF:         n = 0;
        default:              n = -1;
      endcase
      if (n < 0) continue;
      cut = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (pc == 8'hFF) cut = 1'b1;
        else begin a[i] = rom[pc]; pc++; end
      end
      if (cut) break;
      if (op == 8'hFF) break;
      case (op)
        8'h02, 8'h01: begin
          m_mem[3] = a[0]; m_mem[0] = a[1];
          if (op == 8'h02) m_mem[1] = a[2];
          v = alu_fn(m_mem[3], m_mem[0], m_mem[1]);
          m_mem[2] = v; m_result = v;
        end
        8'hC2: begin m_mem[a[0][3:0]] = a[1]; m_result = a[1]; end
        8'hE2: begin v = m_mem[a[1][3:0]]; m_mem[a[0][3:0]] = v; m_result = v; end
        8'h81: m_prints.push_back(m_mem[a[0][3:0]]);
        8'hAA: begin ret = pc; rv = 1'b1; pc = a[0]; end
        8'hDA: if (m_mem[2] == 8'h01) begin ret = pc; rv = 1'b1; pc = a[0]; end
        8'h55: if (rv) begin pc = ret; rv = 1'b0; end
        default: ;
      endcase
    end
    m_pc = pc;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{128'h00117EFF, 4, 8'h00, 128'h0, 0, 0, 8'h00, 8'h00, 8'h04};
    tbl[1] = '{128'h7E02000507810_2FF >> 4, 8, 8'h00, 128'h0, 0, 1, 8'h0C, 8'h0C, 8'h08};
    tbl[1].prog = 128'h7E0200050781_02FF;
    tbl[2] = '{128'h7EC209ABE20A09810AFF, 10, 8'h00, 128'h0, 0, 1, 8'hAB, 8'hAB, 8'h0A};
    tbl[3] = '{128'h7EC2095AAA0C55FF, 8, 8'h0C, 128'h810955, 3, 1, 8'h5A, 8'h5A, 8'h08};
    tbl[4] = '{128'h7E0205030_3DA10C20422_8104FF >> 0, 13, 8'h10, 128'h810055, 3,
               2, 8'h03, 8'h22, 8'h0D};
    tbl[4].prog = 128'h7E02050303DA10C204228104FF;
    tbl[5] = '{128'h7E02050304DA10C204228104FF, 13, 8'h10, 128'h810055, 3,
               1, 8'h22, 8'h22, 8'h0D};
    tbl[6] = '{128'h7E33020001020101098102FF, 12, 8'h00, 128'h0, 0, 1, 8'h07, 8'h07, 8'h0C};
    tbl[7] = '{128'h7E55C21F66810FFF, 8, 8'h00, 128'h0, 0, 1, 8'h66, 8'h66, 8'h08};

    for (int i = 0; i < 8; i++) begin
      rom_clear();
      rom_load(8'h00, tbl[i].prog, tbl[i].len);
      rom_load(tbl[i].sub_at, tbl[i].sub, tbl[i].sub_len);
      do_reset();
      wait_halt(2000);
      chk($sformatf("tbl%0d_nprint", i), 32'(nprint()), 32'(tbl[i].n_prints));
      if (tbl[i].n_prints > 0 && nprint() > 0)
        chk($sformatf("tbl%0d_print0", i), 32'(got_q[got_base]), 32'(tbl[i].first_print));
      chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].exp_result));
      chk($sformatf("tbl%0d_pc", i), 32'(imem_addr), 32'(tbl[i].exp_pc));
      chk($sformatf("tbl%0d_running", i), 32'(running), 32'd0);
    end

    // Reset state
    rst = 1'b1; #1;
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_slots", 32'({alu_op, alu_a, alu_b}), 32'd0);

    // Scan timing: 7E captured at the sixth edge
    rom_clear(); rom_load(8'h00, tbl[0].prog, tbl[0].len);
    do_reset();
    step(5); chk("scan_running_early", 32'(running), 32'd0);
    step(1); chk("scan_running", 32'(running), 32'd1);

    // ALU latency: OP_ISSUE in cycle 3, result at edge 11
    rom_clear(); rom_load(8'h00, tbl[1].prog, tbl[1].len);
    do_reset();
    step(10);
    chk("alu_result_early", 32'(result), 32'd0);
    chk("alu_slot_op", 32'(alu_op), 32'h00);
    chk("alu_slot_a", 32'(alu_a), 32'h05);
    chk("alu_slot_b", 32'(alu_b), 32'h07);
    step(1); chk("alu_result_time", 32'(result), 32'h0C);

    // Store latency: result at edge 9
    rom_clear(); rom_load(8'h00, tbl[2].prog, tbl[2].len);
    do_reset();
    step(8); chk("store_result_early", 32'(result), 32'd0);
    step(1); chk("store_result_time", 32'(result), 32'hAB);

    // Backpressure: output held while out_ready is low
    rom_clear(); rom_load(8'h00, tbl[1].prog, tbl[1].len);
    do_reset();
    out_ready = 1'b0;
    wait_out_valid(50);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_data_hold", 32'(out_data), 32'h0C);
    end
    out_ready = 1'b1;
    step(1); chk("bp_valid_drop", 32'(out_valid), 32'd0);
    wait_halt(100);
    chk("bp_nprint", 32'(nprint()), 32'd1);

    // Enable freeze mid-fetch
    rom_clear(); rom_load(8'h00, tbl[0].prog, tbl[0].len);
    do_reset();
    step(3); chk("en_addr_before", 32'(imem_addr), 32'd1);
    enable = 1'b0;
    step(4);
    chk("en_addr_frozen", 32'(imem_addr), 32'd1);
    chk("en_running_frozen", 32'(running), 32'd0);
    enable = 1'b1;
    step(1); chk("en_addr_resume", 32'(imem_addr), 32'd2);

    // Asynchronous reset during OUT_WAIT, then a clean rerun
    rom_clear(); rom_load(8'h00, tbl[1].prog, tbl[1].len);
    do_reset();
    out_ready = 1'b0;
    wait_out_valid(50);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    wait_halt(200);
    chk("arst_rerun_result", 32'(result), 32'h0C);

    // Start byte just below the terminal address
    rom_clear(); rom[254] = 8'h7E; rom[255] = 8'h81;
    do_reset();
    wait_halt(800);
    chk("term_saw_running", 32'(saw_running), 32'd1);
    chk("term_running", 32'(running), 32'd0);
    chk("term_addr", 32'(imem_addr), 32'hFF);
    chk("term_no_print", 32'(out_valid), 32'd0);

    // No start byte at all
    rom_clear();
    do_reset();
    wait_halt(800);
    chk("noscan_saw_running", 32'(saw_running), 32'd0);
    chk("noscan_addr", 32'(imem_addr), 32'hFF);

    // Random programs with random enable and out_ready
    for (int t = 0; t < 40; t++) begin
      int k = 0;
      gen_prog();
      model_run();
      do_reset();
      while (!halted && k < 4000) begin
        out_ready = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 3) != 0);
        step(1);
        k++;
      end
      enable = 1'b1; out_ready = 1'b1;
      chk($sformatf("rnd%0d_halted", t), 32'(halted), 32'd1);
      chk($sformatf("rnd%0d_nprint", t), 32'(nprint()), 32'(m_prints.size()));
      for (int i = 0; i < m_prints.size() && i < nprint(); i++)
        chk($sformatf("rnd%0d_print%0d", t, i), 32'(got_q[got_base + i]), 32'(m_prints[i]));
      chk($sformatf("rnd%0d_result", t), 32'(result), 32'(m_result));
      chk($sformatf("rnd%0d_slot_op", t), 32'(alu_op), 32'(m_mem[3]));
      chk($sformatf("rnd%0d_slot_a", t), 32'(alu_a), 32'(m_mem[0]));
      chk($sformatf("rnd%0d_slot_b", t), 32'(alu_b), 32'(m_mem[1]));
      chk($sformatf("rnd%0d_pc", t), 32'(imem_addr), 32'(m_pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bytecode_sequencer.md
Name: bytecode_sequencer

Overview:
Synchronous fetch/decode/execute controller for the 8-bit bytecode datapath. It reads bytecode bytes from a synchronous instruction ROM and decodes them. It sequences the external alu through operand slots in a small scratch memory. It also handles stores, moves, single-level call/return, printing through an output handshake, and halt.

Parameters:
ADDR_W, 8, instruction address width; address 2^ADDR_W-1 is the terminal address
DMEM_DEPTH, 16, scratch memory bytes (power of two); addresses taken modulo DMEM_DEPTH
START_BYTE, 8'h7E, marker that ends the pre-start scan

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run enable; low freezes all state
imem_addr  out  ADDR_W  ROM read address
imem_data  in  8  ROM data, valid one cycle after imem_addr
alu_op  out  8  scratch slot 3
alu_a  out  8  scratch slot 0
alu_b  out  8  scratch slot 1
alu_result  in  8  combinational alu output
result  out  8  last value written by an ALU/store/move instruction
out_valid  out  1  print data valid
out_data  out  8  print value
out_ready  in  1  print consumer ready
running  out  1  high after START_BYTE is seen, until halt
halted  out  1  sticky halt flag

Behaviour:
- One clock: clk. Reset is asynchronous and active-high (rst).
- Reset values:
  - pc=0, imem_addr=0, state=SCAN_ISSUE.
  - result=0, out_valid=0, out_data=0, running=0, halted=0.
  - All scratch bytes=0; ret_addr=0; ret_valid=0.
- enable=0: no register changes. out_valid and out_data hold their values.
- Byte fetch: ISSUE drives imem_addr=pc. CAPTURE latches imem_data and increments pc. Each byte takes 2 cycles.
- States: SCAN_ISSUE, SCAN_CAP, OP_ISSUE, OP_CAP, ARG_ISSUE, ARG_CAP, EXEC, OUT_WAIT, HALT.
- SCAN: fetch bytes in sequence. A byte equal to START_BYTE sets running=1, then go to OP_ISSUE. Any other byte is skipped.
- OP_CAP decodes the opcode and sets the argument count n. n=0 goes to EXEC; otherwise fetch n arguments through ARG_ISSUE/ARG_CAP, then EXEC.
- Opcodes (n in parentheses):
  - 8'h02 (3): slot3=op, slot0=a, slot1=b.
  - 8'h01 (2): slot3=op, slot0=a; slot1 unchanged.
  - 8'hC2 (2): mem[x]=y.
  - 8'hE2 (2): mem[x]=mem[y].
  - 8'h81 (1): print mem[x].
  - 8'hAA (1): call target.
  - 8'hDA (1): conditional call. The target byte is always consumed.
  - 8'h55 (0): return.
  - 8'hFF (0): halt.
  - Any other byte: no-op, back to OP_ISSUE.
- EXEC (1 cycle):
  - 02/01: slot2=alu_result and result=alu_result. The alu sees the new slots during EXEC.
  - C2/E2: perform the write; result=written value. The E2 source is read before the write, so x==y writes the same value back.
  - 81: out_data=mem[x], out_valid=1, go to OUT_WAIT.
  - AA: ret_addr=pc (the address after the operand), ret_valid=1, pc=target.
  - DA: if slot2==8'h01, act as AA. Otherwise continue at pc.
  - 55: if ret_valid, pc=ret_addr and ret_valid=0. Otherwise no-op.
  - FF: go to HALT.
- Call nesting depth is 1. A call while ret_valid=1 overwrites ret_addr.
- OUT_WAIT: hold out_valid and out_data until a cycle with out_valid&&out_ready. In that cycle clear out_valid and go to OP_ISSUE. If out_ready is already high on the first OUT_WAIT cycle, that is a 1-cycle stall.
- HALT: halted=1, running=0, no fetches. Only rst leaves HALT.
- Terminal address: if any ISSUE state has pc==2^ADDR_W-1, go to HALT instead of fetching. This applies in SCAN and mid-instruction.
- pc arithmetic is modulo 2^ADDR_W. Scratch addresses use the low log2(DMEM_DEPTH) bits.
- Latency examples: an ALU instruction takes 9 cycles from OP_ISSUE to the result update (4 bytes x 2 + 1). A store takes 7 cycles.
- rst mid-instruction or during OUT_WAIT aborts immediately and returns to the reset state, including out_valid=0.

Test Plan:
- Start scan: ROM 00,11,7E,FF -> running=1 after the byte at address 2 is captured; halted=1 after the FF executes; pc=4.
- ALU: bench alu uses op 00=add. ROM 7E,02,00,05,07,81,02,FF with out_ready=1 -> result=12 at the EXEC cycle; one out_valid pulse with out_data=12; then halt.
- Store/move: 7E,C2,09,AB,E2,0A,09,81,0A,FF -> mem[9]=AB, mem[A]=AB, result=AB, out_data=AB.
- Call/return: AA to a subroutine printing mem[9] and ending in 55 -> print occurs, execution resumes at the byte after the AA operand; a second 55 acts as a no-op.
- Conditional call: alu op 05=equal. With a=b=3, DA taken; with a=3, b=4, not taken, the operand is skipped, and the next opcode executes.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> out_valid and out_data stable; toggle enable=0 mid-fetch -> pc frozen; assert rst in OUT_WAIT -> out_valid=0 and state=SCAN_ISSUE asynchronously. Also place the program at 2^ADDR_W-2 -> HALT without fetching address 255.
